// File: rtl/alu_writeback_unit_pkg.sv
// Shared types and defaults for the ALU writeback stage.
package alu_writeback_unit_pkg;

    localparam int DEF_REG_ADDR_W = 5;
    localparam int DEF_DATA_W     = 32;
    localparam int WR_COUNT_W     = 16;

    // Write sequencing states: a wide result parks its HI word in PEND_HI.
    typedef enum logic [0:0] {
        WB_IDLE    = 1'b0,
        WB_PEND_HI = 1'b1
    } wb_state_e;

    // Architectural flag bundle, MSB first: {carry, zero, sign, ovf}.
    typedef struct packed {
        logic carry;
        logic zero;
        logic sign;
        logic ovf;
    } flags_t;

endpackage : alu_writeback_unit_pkg

// File: rtl/alu_writeback_unit_if.sv
// ALU-to-writeback result bus with valid/ready handshake.
interface alu_writeback_unit_if #(
    parameter int REG_ADDR_W = 5,
    parameter int DATA_W     = 32
);

    logic                  wb_valid;
    logic                  wb_ready;
    logic [REG_ADDR_W-1:0] wb_rd;
    logic                  wb_is_wide;
    logic [DATA_W-1:0]     wb_lo;
    logic [DATA_W-1:0]     wb_hi;
    logic                  wb_flag_en;
    logic                  wb_carry;
    logic                  wb_zero;
    logic                  wb_sign;
    logic                  wb_ovf;

    // ALU side: offers results, observes back-pressure.
    modport master (
        output wb_valid, wb_rd, wb_is_wide, wb_lo, wb_hi,
        output wb_flag_en, wb_carry, wb_zero, wb_sign, wb_ovf,
        input  wb_ready
    );

    // Writeback side: consumes results, drives back-pressure.
    modport slave (
        input  wb_valid, wb_rd, wb_is_wide, wb_lo, wb_hi,
        input  wb_flag_en, wb_carry, wb_zero, wb_sign, wb_ovf,
        output wb_ready
    );

endinterface : alu_writeback_unit_if

// File: rtl/alu_writeback_unit_wb_flag_reg.sv
// Architectural flag register: loads all four flags together when enabled.
module wb_flag_reg
    import alu_writeback_unit_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   load,
    input  flags_t d,
    output flags_t q
);

    // Flag storage; holds unless a flag-updating result is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking (<=) so every register
        // samples pre-edge values regardless of process ordering.
        if (!rst_n) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule : wb_flag_reg

// File: rtl/alu_writeback_unit.sv
// ALU writeback stage: issues register-file writes (LO, then HI for wide
// results), back-pressures the ALU while HI is pending, owns the flags.
module alu_writeback_unit
    import alu_writeback_unit_pkg::*;
#(
    parameter int REG_ADDR_W   = DEF_REG_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int R0_READ_ONLY = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    alu_writeback_unit_if.slave   wb,
    input  logic                  flush,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0]     rf_wdata,
    output logic                  flag_carry,
    output logic                  flag_zero,
    output logic                  flag_sign,
    output logic                  flag_ovf,
    output logic [WR_COUNT_W-1:0] wr_count
);

    wb_state_e             state_q, state_d;
    logic [REG_ADDR_W-1:0] hi_addr_q, hi_addr_d;
    logic [DATA_W-1:0]     hi_data_q, hi_data_d;

    logic                  accept;
    logic                  wr_fire;
    logic                  we_d;
    logic [REG_ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0]     wr_data;

    flags_t                flags_d, flags_q;

    assign wb.wb_ready = (state_q == WB_IDLE);
    assign accept      = wb.wb_valid && wb.wb_ready && !flush;

    // Next-state and write selection for the LO/HI sequencer.
    always_comb begin
        // NOTE: every output of this block gets a default first so no
        // path leaves it unassigned and no latch is inferred.
        state_d   = state_q;
        hi_addr_d = hi_addr_q;
        hi_data_d = hi_data_q;
        wr_fire   = 1'b0;
        wr_addr   = rf_waddr;
        wr_data   = rf_wdata;

        unique case (state_q)
            WB_IDLE: begin
                if (accept) begin
                    wr_fire = 1'b1;
                    wr_addr = wb.wb_rd;
                    wr_data = wb.wb_lo;
                    if (wb.wb_is_wide) begin
                        // HI target wraps naturally at the address width.
                        hi_addr_d = wb.wb_rd + REG_ADDR_W'(1);
                        hi_data_d = wb.wb_hi;
                        state_d   = WB_PEND_HI;
                    end
                end
            end
            WB_PEND_HI: begin
                // New offers are ignored here; flush drops the HI word.
                state_d = WB_IDLE;
                if (!flush) begin
                    wr_fire = 1'b1;
                    wr_addr = hi_addr_q;
                    wr_data = hi_data_q;
                end
            end
            default: state_d = WB_IDLE;
        endcase

        // Writes to r0 still move address/data but never strobe.
        we_d = wr_fire && !((R0_READ_ONLY != 0) && (wr_addr == '0));
    end

    // Sequencer state and pending HI word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= WB_IDLE;
            hi_addr_q <= '0;
            hi_data_q <= '0;
        end else begin
            state_q   <= state_d;
            hi_addr_q <= hi_addr_d;
            hi_data_q <= hi_data_d;
        end
    end

    // Registered register-file write port and issued-write counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
            wr_count <= '0;
        end else begin
            rf_we    <= we_d;
            rf_waddr <= wr_addr;
            rf_wdata <= wr_data;
            if (we_d) begin
                wr_count <= wr_count + WR_COUNT_W'(1);
            end
        end
    end

    assign flags_d = {wb.wb_carry, wb.wb_zero, wb.wb_sign, wb.wb_ovf};

    wb_flag_reg u_flag_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (accept && wb.wb_flag_en),
        .d     (flags_d),
        .q     (flags_q)
    );

    assign flag_carry = flags_q.carry;
    assign flag_zero  = flags_q.zero;
    assign flag_sign  = flags_q.sign;
    assign flag_ovf   = flags_q.ovf;

endmodule : alu_writeback_unit

// File: tb/tb_alu_writeback_unit.sv
// Self-checking bench for alu_writeback_unit: directed scenarios plus random
// traffic, compared against a queue-based reference model.
module tb_alu_writeback_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        flag_carry, flag_zero, flag_sign, flag_ovf;
    logic [15:0] wr_count;

    int n_tests = 0;
    int n_fail  = 0;

    alu_writeback_unit_if #(.REG_ADDR_W(5), .DATA_W(32)) wb_if ();

    alu_writeback_unit #(.REG_ADDR_W(5), .DATA_W(32), .R0_READ_ONLY(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wb         (wb_if),
        .flush      (flush),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .flag_carry (flag_carry),
        .flag_zero  (flag_zero),
        .flag_sign  (flag_sign),
        .flag_ovf   (flag_ovf),
        .wr_count   (wr_count)
    );

    always #5 clk = ~clk;

    // Reference model: scheduled HI writes wait in a queue; while one is
    // queued the unit refuses new results.
    typedef struct {
        int          addr;
        logic [31:0] data;
    } wr_t;

    wr_t         hi_q[$];
    logic        m_we;
    int          m_addr;
    logic [31:0] m_data;
    int          m_cnt;
    logic [3:0]  m_flags;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        hi_q.delete();
        m_we    = 1'b0;
        m_addr  = 0;
        m_data  = '0;
        m_cnt   = 0;
        m_flags = '0;
    endtask

    function automatic logic [3:0] dut_flags();
        return {flag_carry, flag_zero, flag_sign, flag_ovf};
    endfunction

    task automatic check_all(input string tag);
        check({tag, ".we"},    32'(rf_we),       32'(m_we));
        check({tag, ".addr"},  32'(rf_waddr),    32'(m_addr));
        check({tag, ".data"},  rf_wdata,         m_data);
        check({tag, ".flags"}, 32'(dut_flags()), 32'(m_flags));
        check({tag, ".cnt"},   32'(wr_count),    32'(m_cnt));
        check({tag, ".ready"}, 32'(wb_if.wb_ready), 32'(hi_q.size() == 0));
    endtask

    // Record one issued write in the model (r0 never strobes).
    task automatic model_write(input int addr, input logic [31:0] data);
        m_addr = addr;
        m_data = data;
        m_we   = (addr != 0);
        if (m_we) m_cnt = (m_cnt + 1) % 65536;
    endtask

    // Advance one clock: update the model from the currently driven inputs,
    // then compare every output just after the edge.
    task automatic cycle(input string tag);
        bit ready_now;
        wr_t w;
        ready_now = (hi_q.size() == 0);
        check({tag, ".pre_ready"}, 32'(wb_if.wb_ready), 32'(ready_now));
        m_we = 1'b0;
        if (!ready_now) begin
            w = hi_q.pop_front();
            if (!flush) model_write(w.addr, w.data);
        end else if (wb_if.wb_valid && !flush) begin
            model_write(int'(wb_if.wb_rd), wb_if.wb_lo);
            if (wb_if.wb_is_wide) begin
                w.addr = (int'(wb_if.wb_rd) + 1) % 32;
                w.data = wb_if.wb_hi;
                hi_q.push_back(w);
            end
            if (wb_if.wb_flag_en)
                m_flags = {wb_if.wb_carry, wb_if.wb_zero, wb_if.wb_sign, wb_if.wb_ovf};
        end
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic drive(input logic v, input logic [4:0] rd, input logic wide,
                         input logic [31:0] lo, input logic [31:0] hi,
                         input logic fen, input logic [3:0] f, input logic fl);
        wb_if.wb_valid   = v;
        wb_if.wb_rd      = rd;
        wb_if.wb_is_wide = wide;
        wb_if.wb_lo      = lo;
        wb_if.wb_hi      = hi;
        wb_if.wb_flag_en = fen;
        {wb_if.wb_carry, wb_if.wb_zero, wb_if.wb_sign, wb_if.wb_ovf} = f;
        flush            = fl;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 1'b0, 4'b0000, 1'b0);
    endtask

    initial begin
        int cnt0;

        // Reset state.
        rst_n = 1'b0;
        idle();
        model_reset();
        #1;
        check_all("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Narrow add to r5 with carry set.
        drive(1'b1, 5'd5, 1'b0, 32'h0000_0007, 32'h0, 1'b1, 4'b1000, 1'b0);
        cycle("narrow");
        check("narrow.addr5", 32'(rf_waddr), 32'd5);
        check("narrow.data7", rf_wdata, 32'd7);
        check("narrow.carry", 32'(flag_carry), 32'd1);
        check("narrow.cnt1", 32'(wr_count), 32'd1);

        // Wide multiply to r8 with a narrow op offered right behind it.
        cnt0 = m_cnt;
        drive(1'b1, 5'd8, 1'b1, 32'h89AB_CDEF, 32'h0123_4567, 1'b1, 4'b0100, 1'b0);
        cycle("wide_lo");
        check("wide_lo.data", rf_wdata, 32'h89AB_CDEF);
        check("wide_lo.busy", 32'(wb_if.wb_ready), 32'd0);
        drive(1'b1, 5'd3, 1'b0, 32'h0000_0055, 32'h0, 1'b0, 4'b0000, 1'b0);
        cycle("wide_hi");
        check("wide_hi.addr9", 32'(rf_waddr), 32'd9);
        check("wide_hi.data", rf_wdata, 32'h0123_4567);
        check("wide_hi.cnt", 32'(wr_count), 32'(cnt0 + 2));
        cycle("after_wide");
        check("after_wide.addr3", 32'(rf_waddr), 32'd3);

        // Wide to r31: HI wraps to r0 and is suppressed.
        cnt0 = m_cnt;
        drive(1'b1, 5'd31, 1'b1, 32'hAAAA_0001, 32'hBBBB_0002, 1'b0, 4'b0000, 1'b0);
        cycle("wrap_lo");
        idle();
        cycle("wrap_hi");
        check("wrap_hi.we0", 32'(rf_we), 32'd0);
        check("wrap_hi.addr0", 32'(rf_waddr), 32'd0);
        check("wrap_hi.cnt", 32'(wr_count), 32'(cnt0 + 1));

        // Flush during PEND_HI after a wide op to r10.
        drive(1'b1, 5'd10, 1'b1, 32'h1010_1010, 32'h2020_2020, 1'b1, 4'b0110, 1'b0);
        cycle("flush_lo");
        drive(1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 1'b1, 4'b1001, 1'b1);
        cycle("flush_hi");
        check("flush_hi.we0", 32'(rf_we), 32'd0);
        check("flush_hi.ready", 32'(wb_if.wb_ready), 32'd1);
        check("flush_hi.flags", 32'(dut_flags()), 32'b0110);

        // Flush with an offer in IDLE: nothing happens.
        drive(1'b1, 5'd4, 1'b0, 32'hDEAD_BEEF, 32'h0, 1'b1, 4'b1111, 1'b1);
        cycle("flush_idle");

        // flag_en=0 leaves zero flag clear.
        drive(1'b1, 5'd6, 1'b0, 32'h1, 32'h0, 1'b1, 4'b0000, 1'b0);
        cycle("flags_clear");
        drive(1'b1, 5'd7, 1'b0, 32'h0, 32'h0, 1'b0, 4'b0100, 1'b0);
        cycle("flag_en0");
        check("flag_en0.zero", 32'(flag_zero), 32'd0);
        check("flag_en0.we", 32'(rf_we), 32'd1);

        // Random traffic.
        for (int i = 0; i < 500; i++) begin
            drive($urandom_range(0, 3) != 0, 5'($urandom), $urandom_range(0, 2) == 0,
                  $urandom, $urandom, 1'($urandom), 4'($urandom),
                  $urandom_range(0, 9) == 0);
            cycle("rand");
        end

        // Asynchronous reset in the middle of PEND_HI.
        drive(1'b1, 5'd12, 1'b1, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 4'b1111, 1'b0);
        cycle("rst_lo");
        idle();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("async_rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle("post_rst");
        check("post_rst.we0", 32'(rf_we), 32'd0);

        // Counter wrap: run up to 0xFFFF issued writes, then one more.
        drive(1'b1, 5'd1, 1'b0, 32'h0000_0001, 32'h0, 1'b0, 4'b0000, 1'b0);
        for (int i = 0; i < 65535; i++) begin
            wb_if.wb_lo = 32'(i);
            cycle("fill");
        end
        check("fill.ffff", 32'(wr_count), 32'h0000_FFFF);
        cycle("cnt_wrap");
        check("cnt_wrap.zero", 32'(wr_count), 32'd0);
        check("cnt_wrap.we", 32'(rf_we), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_alu_writeback_unit

// File: doc/alu_writeback_unit.md
Name: alu_writeback_unit

Overview:
- Stage directly downstream of the ALU: consumes the ALU result word, the extended (upper) word, and the four status flags.
- Produces register-file write strobes and holds the architectural flag register read by the branch logic.
- Splits 64-bit multiply results into two sequential single-port writes (LO then HI) and back-pressures the ALU while the HI write is pending.

Parameters:
- REG_ADDR_W, 5, register-file address width.
- DATA_W, 32, data word width.
- R0_READ_ONLY, 1, when 1 any write addressed to register 0 is suppressed (rf_we held 0).

Ports:
- clk  input  1  single system clock, all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- wb_valid  input  1  ALU result valid this cycle.
- wb_ready  output  1  unit can accept a result this cycle.
- wb_rd  input  REG_ADDR_W  destination register for the LO word.
- wb_is_wide  input  1  result is 64-bit (multiply); HI word must also be written.
- wb_lo  input  DATA_W  ALU primary result.
- wb_hi  input  DATA_W  ALU extended result (upper product word).
- wb_flag_en  input  1  instruction updates flags.
- wb_carry, wb_zero, wb_sign, wb_ovf  input  1 each  ALU flags.
- flush  input  1  synchronous kill of the pending HI write and the current offer.
- rf_we  output  1  register-file write enable (registered).
- rf_waddr  output  REG_ADDR_W  write address (registered).
- rf_wdata  output  DATA_W  write data (registered).
- flag_carry, flag_zero, flag_sign, flag_ovf  output  1 each  architectural flag register.
- wr_count  output  16  count of rf writes actually issued, wraps at 2^16.

Behaviour:
- Reset (rst_n low, asynchronous):
  - Every output is 0 except wb_ready, which is 1.
  - State returns to IDLE; the pending HI address/data registers clear.
  - Reset mid-HI drops the HI write.
- States: IDLE, PEND_HI. wb_ready = (state == IDLE).
- Accept is wb_valid && wb_ready && !flush.
- IDLE, accept:
  - Next edge: rf_we=1, rf_waddr=wb_rd, rf_wdata=wb_lo.
  - If wb_is_wide: capture wb_hi and hi address (wb_rd+1 mod 2^REG_ADDR_W), go to PEND_HI.
  - Otherwise remain IDLE.
- IDLE, no accept: next edge rf_we=0; rf_waddr/rf_wdata hold their last value.
- PEND_HI, !flush: next edge rf_we=1, rf_waddr=hi address, rf_wdata=captured HI; go to IDLE. wb_valid is ignored.
- PEND_HI, flush: next edge rf_we=0; go to IDLE; HI is discarded.
- Latency: 1 cycle from accept to LO write; a wide result writes HI exactly 1 cycle after LO.
- Throughput: 1 result/cycle narrow; 1 wide result per 2 cycles.
- Flags:
  - On accept with wb_flag_en=1, all four flags load from inputs at the same edge the LO write appears.
  - wb_flag_en=0 or no accept: flags hold.
  - flush never alters flags.
- R0 suppression: if R0_READ_ONLY=1 and the target address is 0, rf_we=0 for that write. rf_waddr/rf_wdata still update. The state sequence is unchanged: a wide op to r31 writes HI to r0 and is suppressed.
- wr_count increments by 1 on every edge where rf_we goes out as 1; it wraps 0xFFFF→0.
- flush with wb_valid in IDLE: no accept, no write, no flag update.

Decomposition:
- Shared package:
  - State enum (IDLE, PEND_HI).
  - Flag bundle ordering {carry, zero, sign, ovf}.
  - REG_ADDR_W/DATA_W defaults.
- One natural sub-module, wb_flag_reg: the 4-bit flag register with load enable and async active-low reset. The write sequencing FSM stays in the top module.

Test Plan:
- Reset then narrow add: wb_rd=5, wb_lo=0x0000_0007, flag_en=1, flags c=1 z=0 s=0 o=0 → next cycle rf_we=1, addr=5, data=7; flag_carry=1; wr_count=1.
- Wide multiply: wb_rd=8, lo=0x89AB_CDEF, hi=0x0123_4567, back-to-back narrow op offered → cycle+1 write r8=0x89AB_CDEF with wb_ready=0; cycle+2 write r9=0x0123_4567; narrow op accepted only in cycle+2; wr_count=2 before narrow op writes.
- Wrap: wide op with wb_rd=31 → r31 written; HI address 0 gives rf_we=0 (R0_READ_ONLY=1); wr_count +1 only.
- Flush during PEND_HI after wide op to r10 → only r10 written, no HI write, wb_ready=1 next cycle, flags keep values from the wide op.
- flag_en=0 narrow op with zero=1 input after flags set to z=0 → write occurs, flag_zero stays 0.
- Assert rst_n low asynchronously mid-PEND_HI → outputs immediately 0, wb_ready=1, no HI write after release; wr_count wraps from 0xFFFF to 0 on a further write (preload via 65535 writes or force).
